// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//   Round-robin arbiter that owns the select of a shared 2:1 mux between two
//   requesters, A and B. Ownership bursts are capped at MAX_BURST cycles. When
//   the other requester is waiting at the cap, ownership is handed over
//   directly with no idle bubble.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req_a/b    request from A / B
//   a, b       requester data (mux inputs 0 / 1)
//   gnt_a/b    registered one-hot-or-zero grants
//   sel        registered mux select (0 -> a, 1 -> b); holds its value in IDLE
//   y          combinational mux output, sel ? b : a
//   y_valid    high while either grant is high
//   burst_cnt  cycles already spent in the current burst
// -----------------------------------------------------------------------------

// One bit of the shared datapath.
module mux_rr_lane (
    input  logic i0,
    input  logic i1,
    input  logic s,
    output logic o
);
    assign o = s ? i1 : i0;
endmodule

module mux_rr_arbiter #(
    parameter int WIDTH     = 1,
    parameter int MAX_BURST = 4,
    localparam int CW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic [CW-1:0]    burst_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    state_t state;
    state_t nxt_state;
    logic   last_b;      // 1: B owned the mux most recently, so A wins a tie
    logic   at_limit;

    assign at_limit = (burst_cnt == CNT_LAST);

    // Next-state decision. Only the current owner's request and the
    // contender's request matter; the cap only forces a handover when the
    // contender is actually waiting.
    always_comb begin
        nxt_state = IDLE;
        case (state)
            IDLE: begin
                if (req_a && req_b) nxt_state = last_b ? GNT_A : GNT_B;
                else if (req_a)     nxt_state = GNT_A;
                else if (req_b)     nxt_state = GNT_B;
                else                nxt_state = IDLE;
            end
            GNT_A: begin
                if (!req_a)                nxt_state = req_b ? GNT_B : IDLE;
                else if (at_limit && req_b) nxt_state = GNT_B;
                else                        nxt_state = GNT_A;
            end
            GNT_B: begin
                if (!req_b)                nxt_state = req_a ? GNT_A : IDLE;
                else if (at_limit && req_a) nxt_state = GNT_A;
                else                        nxt_state = GNT_B;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // All outputs except y are registered from the next state, so they are
    // Moore outputs of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            sel       <= 1'b0;
            y_valid   <= 1'b0;
            burst_cnt <= '0;
            last_b    <= 1'b1;
        end else begin
            state   <= nxt_state;
            gnt_a   <= (nxt_state == GNT_A);
            gnt_b   <= (nxt_state == GNT_B);
            y_valid <= (nxt_state != IDLE);

            case (nxt_state)
                GNT_A: sel <= 1'b0;
                GNT_B: sel <= 1'b1;
                default: ;              // sel holds while idle
            endcase

            if (nxt_state == IDLE) begin
                burst_cnt <= '0;
            end else if (nxt_state != state) begin
                // Fresh entry, from IDLE or a direct handover.
                burst_cnt <= '0;
                last_b    <= (nxt_state == GNT_B);
            end else if (at_limit) begin
                // Cap reached with nobody waiting: keep the grant, new burst.
                burst_cnt <= '0;
            end else begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

    // Shared datapath, one lane per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        mux_rr_lane u_lane (
            .i0 (a[i]),
            .i1 (b[i]),
            .s  (sel),
            .o  (y[i])
        );
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;
    localparam int WIDTH = 1;
    localparam int MB    = 4;
    localparam int CW    = 2;

    logic             clk = 1'b0;
    logic             rst, req_a, req_b;
    logic [WIDTH-1:0] a, b, y;
    logic             gnt_a, gnt_b, sel, y_valid;
    logic [CW-1:0]    burst_cnt;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       ga, gb, s, v;
        logic [1:0] cnt;
        logic       yy;
    } exp_t;
    exp_t sb_q[$];

    // reference model state: 0 idle, 1 A, 2 B
    int         m_st   = 0;
    int         m_cnt  = 0;
    logic       m_lastb = 1'b1;
    logic       m_sel  = 1'b0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .y(y), .y_valid(y_valid),
        .burst_cnt(burst_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs (at negedge), predict, clock, compare.
    task automatic step(input logic r, input logic ra, input logic rb,
                        input logic da, input logic db);
        int   ns;
        exp_t e;
        rst = r; req_a = ra; req_b = rb; a = da; b = db;
        if (r) begin
            m_st = 0; m_cnt = 0; m_sel = 1'b0; m_lastb = 1'b1;
        end else begin
            ns = 0;
            if (m_st == 0) begin
                if (ra && rb) ns = m_lastb ? 1 : 2;
                else if (ra)  ns = 1;
                else if (rb)  ns = 2;
            end else begin
                logic own, oth;
                own = (m_st == 1) ? ra : rb;
                oth = (m_st == 1) ? rb : ra;
                if (!own)                      ns = oth ? 3 - m_st : 0;
                else if (oth && m_cnt == MB-1) ns = 3 - m_st;
                else                           ns = m_st;
            end
            if (ns == 0)          m_cnt = 0;
            else if (ns != m_st) begin m_cnt = 0; m_lastb = (ns == 2); end
            else                  m_cnt = (m_cnt == MB-1) ? 0 : m_cnt + 1;
            if (ns == 1) m_sel = 1'b0;
            if (ns == 2) m_sel = 1'b1;
            m_st = ns;
        end
        e.ga = (m_st == 1); e.gb = (m_st == 2); e.s = m_sel;
        e.v = (m_st != 0); e.cnt = 2'(m_cnt); e.yy = m_sel ? db : da;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        chk("gnt_a", gnt_a, e.ga);
        chk("gnt_b", gnt_b, e.gb);
        chk("sel", sel, e.s);
        chk("y_valid", y_valid, e.v);
        chk("burst_cnt", burst_cnt, e.cnt);
        chk("y", y, e.yy);
        chk("y_mux", y, sel ? b : a);
        chk("onehot", gnt_a & gnt_b, 0);
        chk("valid_eq_gnt", y_valid, gnt_a | gnt_b);
    endtask

    initial begin
        logic [7:0] pat_b;
        logic [1:0] pat_c [8];
        logic [1:0] wrap_c [10];
        pat_b = 8'b0111_1000;       // bit i: gnt_b on step i after release
        pat_c = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        wrap_c = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

        // reset with both requesting
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        chk("rst_gnt_a", gnt_a, 0);
        chk("rst_gnt_b", gnt_b, 0);
        chk("rst_sel", sel, 0);
        chk("rst_cnt", burst_cnt, 0);
        chk("rst_valid", y_valid, 0);
        step(0, 1, 1, 0, 0);
        chk("tie_first_a", gnt_a, 1);
        chk("tie_sel", sel, 0);

        // fairness: AAAA BBBB A with counts cycling
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 0, 1);
            chk("fair_gnt_b", gnt_b, pat_b[i]);
            chk("fair_cnt", burst_cnt, pat_c[i]);
        end

        // A alone: grant held, counter wraps
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 1, 0);
            chk("wrap_gnt_a", gnt_a, 1);
            chk("wrap_cnt", burst_cnt, wrap_c[i]);
        end

        // early release handover at burst_cnt=1
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("early_pre_cnt", burst_cnt, 1);
        step(0, 0, 1, 0, 1);
        chk("early_gnt_b", gnt_b, 1);
        chk("early_sel", sel, 1);
        chk("early_cnt", burst_cnt, 0);

        // single requester B, then drop
        step(0, 0, 1, 0, 1);
        chk("single_y", y, 1);
        chk("single_valid", y_valid, 1);
        step(0, 0, 0, 0, 1);
        chk("drop_valid", y_valid, 0);
        chk("drop_sel_hold", sel, 1);

        // reset mid-burst in GNT_B at burst_cnt=2
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("mid_pre_cnt", burst_cnt, 2);
        step(1, 1, 1, 0, 0);
        chk("mid_gnt_b", gnt_b, 0);
        chk("mid_sel", sel, 0);
        chk("mid_cnt", burst_cnt, 0);
        step(0, 1, 1, 0, 0);
        chk("mid_tie_a", gnt_a, 1);

        // sweep all a/b/req combinations with sporadic reset
        for (int i = 0; i < 64; i++) begin
            logic [3:0] v;
            v = 4'(i);
            step(($urandom_range(0, 7) == 0), v[3], v[2], v[1], v[0]);
        end

        if (sb_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
